sipo_frame_ctrl: RTL and testbench
==================================

// Module: sipo_frame_ctrl
// PURPOSE
//  Sequences a serial-in/parallel-out shift path. Frames a serial bit stream into WIDTH-bit words.
//  Counts received bits and transfers each completed word to a holding register.
//  Presents the word on a valid/ready handshake and flags words lost to backpressure.
//  Sits between a serial source (bit strobe + data) and a parallel word consumer.
// PARAMETERS
//  WIDTH   4   word width in bits (>=2); shift register and dout width
//  CNT_W   3   bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1        rising-edge clock; the only clock
//  rst         in   1        synchronous, active-high reset
//  start       in   1        1-cycle pulse: begin a new frame
//  din         in   1        serial data bit, sampled when din_valid=1
//  din_valid   in   1        bit strobe; one bit per cycle at most
//  dout_ready  in   1        consumer accepts dout this cycle
//  dout        out  WIDTH    completed parallel word (first received bit = MSB)
//  dout_valid  out  1        dout holds an unaccepted word
//  busy        out  1        1 in SHIFT or HOLD
//  bit_cnt     out  CNT_W    bits received in the current frame
//  overrun     out  1        sticky: a bit or word was dropped
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, shift reg=0, dout=0, dout_valid=0, bit_cnt=0, overrun=0.
//   rst has priority over every other input.
//  Shift rule: on an accepted bit, sreg <= {sreg[WIDTH-2:0], din}. Newest bit enters bit 0; bit 0 is LSB.
//  Handshake: a transfer occurs when dout_valid & dout_ready. dout_valid clears the next cycle
//   unless a new word loads in the same cycle. dout is stable while dout_valid=1 and dout_ready=0.
//  FSM states:
//   IDLE : din_valid ignored. start=1 -> SHIFT; sreg<=0 and bit_cnt<=0 on the same edge.
//   SHIFT: din_valid=1 -> shift din in, bit_cnt+1.
//          On the WIDTH-th bit, the word completes on that edge:
//           - if dout_valid=0 or a transfer happens this cycle: dout<={sreg[WIDTH-2:0],din},
//             dout_valid<=1, bit_cnt<=0, then IDLE. Latency: dout_valid rises 1 cycle after the last bit.
//           - otherwise: sreg keeps the full word, then HOLD.
//          start=1 in SHIFT (no bit completing): abort the frame. sreg<=0, bit_cnt<=0, stay SHIFT.
//          start=1 together with the completing bit: the word completes normally, and start is ignored.
//   HOLD : waits for the old word to be taken. On a transfer: dout<=sreg, dout_valid stays 1,
//          bit_cnt<=0, then IDLE.
//          din_valid=1 in HOLD: the bit is dropped and overrun<=1. start in HOLD is ignored.
//  overrun: sticky; cleared only by rst or by start accepted in IDLE.
//  busy = (state!=IDLE). bit_cnt never exceeds WIDTH-1 when observed.
//  Reset mid-frame or in HOLD: the partial or held word is discarded and all outputs return to reset values.
// TESTING (WIDTH=4)
//  1 rst held 2 cycles, then released -> dout=0, dout_valid=0, busy=0, bit_cnt=0, overrun=0.
//  2 start; bits 1,0,1,1 on consecutive cycles; dout_ready=1 -> dout=4'b1011, dout_valid=1
//    one cycle after the 4th bit, high for 1 cycle; busy=0 after.
//  3 word 4'b0110 left unaccepted (dout_ready=0); start; bits 1,1,0,0 -> state HOLD, dout stays 0110.
//    dout_ready=1 for 1 cycle -> dout=4'b1100, dout_valid=1; the next ready clears it.
//  4 in HOLD (from scenario 3), din_valid=1 with din=1 -> overrun=1, dout unchanged.
//    start in IDLE -> overrun=0.
//  5 start; bits 1,1; start; bits 0,0,0,1 -> dout=4'b0001 (aborted bits discarded), bit_cnt resets to 0 at the second start.
//  6 start; bits 1,0 (bit_cnt=2); rst=1 for 1 cycle -> busy=0, bit_cnt=0, dout_valid=0.
//    Next frame 1,1,1,0 -> dout=4'b1110.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out framer: packs WIDTH serial bits (first bit = MSB) into a word,
// presents it on a valid/ready handshake and flags bits dropped while a word is parked.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_din,
  input  logic             i_din_valid,
  input  logic             i_dout_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_dv, w_dv_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shifted;

  assign w_xfer    = r_dv & i_dout_ready;
  assign w_shifted = {r_sreg[WIDTH-2:0], i_din};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_dout_nxt  = r_dout;
    w_dv_nxt    = r_dv & ~w_xfer;
    w_cnt_nxt   = r_cnt;
    w_ovr_nxt   = r_ovr;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = SHIFT;
          w_sreg_nxt  = '0;
          w_cnt_nxt   = '0;
          w_ovr_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (i_din_valid && r_cnt == LAST_CNT) begin
          // Completing bit wins over a coincident start.
          w_sreg_nxt = w_shifted;
          if (!r_dv || w_xfer) begin
            w_dout_nxt  = w_shifted;
            w_dv_nxt    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLD;
          end
        end else if (i_start) begin
          w_sreg_nxt = '0;
          w_cnt_nxt  = '0;
        end else if (i_din_valid) begin
          w_sreg_nxt = w_shifted;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // bit_cnt stays at WIDTH-1 while the finished word waits in sreg.
        if (i_din_valid) w_ovr_nxt = 1'b1;
        if (w_xfer) begin
          w_dout_nxt  = r_sreg;
          w_dv_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sreg <= '0;
      r_dout <= '0;
      r_dv   <= 1'b0;
      r_cnt  <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_dout <= w_dout_nxt;
      r_dv   <= w_dv_nxt;
      r_cnt  <= w_cnt_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dv;
  assign o_busy       = (r_state != IDLE);
  assign o_bit_cnt    = r_cnt;
  assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4): per-cycle vector table plus a reset-mid-frame sequence.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, din, din_valid, dout_ready;
  logic [3:0] dout;
  logic       dout_valid, busy, overrun;
  logic [2:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din), .i_din_valid(din_valid),
    .i_dout_ready(dout_ready), .o_dout(dout), .o_dout_valid(dout_valid), .o_busy(busy),
    .o_bit_cnt(bit_cnt), .o_overrun(overrun)
  );

  typedef struct {
    logic       rst, start, din, dv, rdy;
    logic [3:0] e_dout;
    logic       e_dval, e_busy;
    logic [2:0] e_cnt;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic d, logic v, logic y,
                              logic [3:0] ed, logic edv, logic eb, logic [2:0] ec, logic eo);
    vec_t t;
    t.rst = r; t.start = s; t.din = d; t.dv = v; t.rdy = y;
    t.e_dout = ed; t.e_dval = edv; t.e_busy = eb; t.e_cnt = ec; t.e_ovr = eo;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic s, logic d, logic v, logic y);
    rst = r; start = s; din = d; din_valid = v; dout_ready = y;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(int idx, logic [3:0] ed, logic edv, logic eb, logic [2:0] ec, logic eo);
    chk("dout",       idx, 32'(dout),       32'(ed));
    chk("dout_valid", idx, 32'(dout_valid), 32'(edv));
    chk("busy",       idx, 32'(busy),       32'(eb));
    chk("bit_cnt",    idx, 32'(bit_cnt),    32'(ec));
    chk("overrun",    idx, 32'(overrun),    32'(eo));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    //                rst st din dv rdy  dout   dval busy cnt ovr
    // reset held 2 cycles, then released
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    // frame 1011, consumer ready
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 4'b1011, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1011, 0, 0, 0, 0));
    // frame 0110 left unaccepted
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1011, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b1011, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0110, 1, 0, 0, 0));
    // frame 1100 completes while 0110 still pending -> HOLD
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0110, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0110, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0110, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0110, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0110, 1, 1, 3, 0));
    // bit in HOLD dropped -> overrun; start in HOLD ignored
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0110, 1, 1, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0110, 1, 1, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1100, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1100, 0, 0, 0, 1));
    // start in IDLE clears overrun; abort after 2 bits, then 0001
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1100, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1100, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1100, 0, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1100, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b1100, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b1100, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b1100, 0, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 4'b0001, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 0));
    // start coincident with completing bit is ignored
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0001, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0001, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0001, 0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 4'b1010, 1, 0, 0, 0));
    // completion in the same cycle as a transfer loads directly
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1010, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b1010, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1010, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1010, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 4'b0111, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0111, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].din, vecs[i].dv, vecs[i].rdy);
      check_all(i, vecs[i].e_dout, vecs[i].e_dval, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_ovr);
    end

    // reset mid-frame discards the partial word, then a clean frame 1110
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0);
    check_all(100, 4'b0111, 0, 1, 2, 0);
    drive(1, 0, 0, 0, 0);
    check_all(101, 4'b0000, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    check_all(102, 4'b0000, 0, 1, 3, 0);
    drive(0, 0, 0, 1, 0);
    check_all(103, 4'b1110, 1, 0, 0, 0);
    // reset while a word is pending clears it
    drive(1, 0, 0, 0, 0);
    check_all(104, 4'b0000, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
